// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read forwarding, prioritised writes and
// a pending-write scoreboard; storage is zeroed one entry per cycle after reset.
module regfile_mp #(
  parameter int DEPTH    = 32,
  parameter int WIDTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD*AW-1:0]    rd_addr_out,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR*AW-1:0]    wa,
  input  logic [NUM_WR*WIDTH-1:0] wd,
  input  logic                    claim_en,
  input  logic [AW-1:0]           claim_addr,
  output logic                    ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state;
  logic [AW-1:0]      clr_idx;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   busy;
  logic [DEPTH-1:0]   busy_next;
  logic [NUM_WR-1:0]  wr_ok;

  // A write commits only in RUN and never to a hard-wired zero register.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = (state == RUN) && we[j] &&
                 !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0));
    end
  end

  // Claims are applied after write clears so a same-cycle claim wins.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) busy_next[wa[j*AW +: AW]] = 1'b0;
    end
    if (state == RUN && claim_en) busy_next[claim_addr] = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= '0;
      ready   <= 1'b0;
    end else begin
      busy <= busy_next;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == AW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // No parallel reset on storage; later write ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j]) mem[wa[j*AW +: AW]] <= wd[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] data_reg;
    logic [AW-1:0]    addr_reg;
    logic             busy_reg;

    assign ra = rd_addr[gi*AW +: AW];

    // Forward the winning in-flight write so back-to-back use needs no bubble.
    always_comb begin
      rd_next = mem[ra];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (wa[j*AW +: AW] == ra)) rd_next = wd[j*WIDTH +: WIDTH];
      end
      if ((ZERO_REG != 0) && (ra == '0)) rd_next = '0;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg <= '0;
        addr_reg <= '0;
        busy_reg <= 1'b0;
      end else if (state == RUN && !stall) begin
        data_reg <= rd_next;
        addr_reg <= ra;
        busy_reg <= busy_next[ra];
      end
    end

    assign rd_data[gi*WIDTH +: WIDTH] = data_reg;
    assign rd_addr_out[gi*AW +: AW]   = addr_reg;
    assign rd_busy[gi]                = busy_reg;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected read results,
// a negedge monitor pops and compares them against both DUT instances.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [9:0]  rd_addr = 10'h3ff;
  logic [63:0] rd_data, rd_data_z;
  logic [9:0]  rd_addr_out, rd_addr_out_z;
  logic [1:0]  rd_busy, rd_busy_z;
  logic [1:0]  we = 2'b00;
  logic [9:0]  wa = '0;
  logic [63:0] wd = '0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_addr = '0;
  logic        ready, ready_z;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .stall(stall), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_addr_out(rd_addr_out), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .claim_en(claim_en), .claim_addr(claim_addr),
    .ready(ready)
  );

  regfile_mp #(.ZERO_REG(0)) dut_z0 (
    .clk(clk), .reset(reset), .stall(stall), .rd_addr(rd_addr),
    .rd_data(rd_data_z), .rd_addr_out(rd_addr_out_z), .rd_busy(rd_busy_z),
    .we(we), .wa(wa), .wd(wd), .claim_en(claim_en), .claim_addr(claim_addr),
    .ready(ready_z)
  );

  typedef struct {
    int          tag;
    int          inst;
    int          port;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every read edge whose expectation is due gets compared here.
  always @(negedge clk) begin
    logic [31:0] act_d;
    logic [4:0]  act_a;
    logic        act_b;
    while (q.size() > 0 && q[0].tag <= edge_n) begin
      mon_e = q.pop_front();
      if (mon_e.inst == 0) begin
        act_d = rd_data[mon_e.port*32 +: 32];
        act_a = rd_addr_out[mon_e.port*5 +: 5];
        act_b = rd_busy[mon_e.port];
      end else begin
        act_d = rd_data_z[mon_e.port*32 +: 32];
        act_a = rd_addr_out_z[mon_e.port*5 +: 5];
        act_b = rd_busy_z[mon_e.port];
      end
      checks++;
      if (act_d !== mon_e.data || act_a !== mon_e.addr || act_b !== mon_e.busy) begin
        errors++;
        $display("FAIL %s inst%0d port%0d: got data=%h addr=%0d busy=%b, want data=%h addr=%0d busy=%b",
                 mon_e.name, mon_e.inst, mon_e.port, act_d, act_a, act_b,
                 mon_e.data, mon_e.addr, mon_e.busy);
      end else begin
        $display("ok   %s inst%0d port%0d: data=%h addr=%0d busy=%b",
                 mon_e.name, mon_e.inst, mon_e.port, act_d, act_a, act_b);
      end
    end
  end

  task automatic step(input logic rst, input logic st,
                      input logic [4:0] r0, input logic [4:0] r1,
                      input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic ce, input logic [4:0] ca);
    @(negedge clk);
    reset = rst; stall = st; rd_addr = {r1, r0};
    we = w; wa = {a1, a0}; wd = {d1, d0};
    claim_en = ce; claim_addr = ca;
  endtask

  task automatic idle_rd(input logic [4:0] r0, input logic [4:0] r1);
    step(1'b0, 1'b0, r0, r1, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic push_exp(input int inst, input int port, input logic [31:0] d,
                          input logic [4:0] a, input logic b, input string n);
    exp_t e;
    e.tag = edge_n + 1; e.inst = inst; e.port = port;
    e.data = d; e.addr = a; e.busy = b; e.name = n;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, act, req);
    end else begin
      $display("ok   %s: %0h", n, act);
    end
  endtask

  task automatic wait_ready(input string n);
    int cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ready) break;
    end
    chk(n, 64'(cnt), 64'd32);
  endtask

  initial begin
    // Reset held for two edges with junk on the read address.
    step(1'b1, 1'b0, 5'd7, 5'd9, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd7, 5'd9, 2'b11, 5'd7, 5'd9, 32'd1, 32'd2, 1'b1, 5'd7);
    @(posedge clk); #1;
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_addr_busy_ready", {rd_addr_out, rd_busy, ready}, 64'd0);

    // Release reset while writing and claiming r4 throughout CLEAR.
    step(1'b0, 1'b0, 5'd4, 5'd4, 2'b01, 5'd4, 5'd0, 32'h55, 32'd0, 1'b1, 5'd4);
    wait_ready("clear_len");

    for (int a = 0; a < 16; a++) begin
      idle_rd(5'(2*a), 5'(2*a+1));
      push_exp(0, 0, 32'd0, 5'(2*a), 1'b0, "cleared");
      push_exp(0, 1, 32'd0, 5'(2*a+1), 1'b0, "cleared");
    end

    // Write with same-cycle forwarding, then a plain read.
    step(1'b0, 1'b0, 5'd5, 5'd4, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0, 5'd0);
    push_exp(0, 0, 32'hDEADBEEF, 5'd5, 1'b0, "fwd_r5");
    push_exp(0, 1, 32'd0, 5'd4, 1'b0, "fwd_r4");
    idle_rd(5'd5, 5'd5);
    push_exp(0, 0, 32'hDEADBEEF, 5'd5, 1'b0, "read_r5");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "read_r5");

    // Collision: higher port wins, both forwarded and stored.
    step(1'b0, 1'b0, 5'd7, 5'd7, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 1'b0, 5'd0);
    push_exp(0, 0, 32'h22, 5'd7, 1'b0, "coll_fwd");
    push_exp(0, 1, 32'h22, 5'd7, 1'b0, "coll_fwd");
    step(1'b0, 1'b0, 5'd10, 5'd11, 2'b11, 5'd10, 5'd11, 32'h100, 32'h200, 1'b0, 5'd0);
    push_exp(0, 0, 32'h100, 5'd10, 1'b0, "dual_wr");
    push_exp(0, 1, 32'h200, 5'd11, 1'b0, "dual_wr");
    idle_rd(5'd7, 5'd11);
    push_exp(0, 0, 32'h22, 5'd7, 1'b0, "coll_read");
    push_exp(0, 1, 32'h200, 5'd11, 1'b0, "dual_read");

    // Zero register: discarded with ZERO_REG=1, kept with ZERO_REG=0.
    step(1'b0, 1'b0, 5'd0, 5'd5, 2'b01, 5'd0, 5'd0, 32'h1234, 32'd0, 1'b1, 5'd0);
    push_exp(0, 0, 32'd0, 5'd0, 1'b0, "zero_fwd");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "zero_p1");
    push_exp(1, 0, 32'h1234, 5'd0, 1'b1, "nozero_fwd");
    idle_rd(5'd0, 5'd0);
    push_exp(0, 0, 32'd0, 5'd0, 1'b0, "zero_read");
    push_exp(1, 0, 32'h1234, 5'd0, 1'b1, "nozero_read");

    // Stall: outputs frozen while writes and claims still commit.
    step(1'b0, 1'b0, 5'd3, 5'd5, 2'b01, 5'd3, 5'd0, 32'hA, 32'd0, 1'b0, 5'd0);
    push_exp(0, 0, 32'hA, 5'd3, 1'b0, "pre_stall");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "pre_stall");
    step(1'b0, 1'b1, 5'd8, 5'd9, 2'b01, 5'd3, 5'd0, 32'hB, 32'd0, 1'b0, 5'd0);
    push_exp(0, 0, 32'hA, 5'd3, 1'b0, "stall1");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "stall1");
    step(1'b0, 1'b1, 5'd12, 5'd13, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd12);
    push_exp(0, 0, 32'hA, 5'd3, 1'b0, "stall2");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "stall2");
    step(1'b0, 1'b1, 5'd14, 5'd15, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    push_exp(0, 0, 32'hA, 5'd3, 1'b0, "stall3");
    push_exp(0, 1, 32'hDEADBEEF, 5'd5, 1'b0, "stall3");
    idle_rd(5'd3, 5'd12);
    push_exp(0, 0, 32'hB, 5'd3, 1'b0, "post_stall");
    push_exp(0, 1, 32'd0, 5'd12, 1'b1, "post_stall_claim");

    // Scoreboard: claim visible same cycle, claim beats write, write clears.
    step(1'b0, 1'b0, 5'd9, 5'd12, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd9);
    push_exp(0, 0, 32'd0, 5'd9, 1'b1, "claim_r9");
    push_exp(0, 1, 32'd0, 5'd12, 1'b1, "busy_r12");
    step(1'b0, 1'b0, 5'd9, 5'd9, 2'b10, 5'd0, 5'd9, 32'd0, 32'h99, 1'b1, 5'd9);
    push_exp(0, 0, 32'h99, 5'd9, 1'b1, "claim_wins");
    step(1'b0, 1'b0, 5'd9, 5'd12, 2'b01, 5'd9, 5'd0, 32'h9A, 32'd0, 1'b0, 5'd0);
    push_exp(0, 0, 32'h9A, 5'd9, 1'b0, "write_clears");
    push_exp(0, 1, 32'd0, 5'd12, 1'b1, "busy_r12");
    idle_rd(5'd9, 5'd9);
    push_exp(0, 0, 32'h9A, 5'd9, 1'b0, "r9_idle");

    // Reset mid-RUN discards the write/claim in flight and re-clears.
    step(1'b1, 1'b0, 5'd9, 5'd12, 2'b01, 5'd9, 5'd0, 32'h77, 32'd0, 1'b1, 5'd20);
    @(posedge clk); #1;
    chk("rerst_outputs", {rd_data[31:0], rd_busy, ready}, 64'd0);
    idle_rd(5'd9, 5'd12);
    wait_ready("reclear_len");
    idle_rd(5'd9, 5'd12);
    push_exp(0, 0, 32'd0, 5'd9, 1'b0, "rerst_r9");
    push_exp(0, 1, 32'd0, 5'd12, 1'b0, "rerst_r12");
    idle_rd(5'd20, 5'd3);
    push_exp(0, 0, 32'd0, 5'd20, 1'b0, "rerst_r20");
    push_exp(0, 1, 32'd0, 5'd3, 1'b0, "rerst_r3");

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the decode stage: `NUM_RD` registered read ports with write-to-read forwarding, `NUM_WR` prioritised write ports, and a per-register pending-write scoreboard. After reset, a clear state machine zeroes storage one entry per cycle, so the array maps to distributed RAM without a parallel reset. Read outputs freeze on `stall`; writes and scoreboard updates never stall.

## Interface
- `DEPTH`, 32: number of registers; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `WIDTH`, 32: data width.
- `NUM_RD`, 2: read ports, ≥ 1.
- `NUM_WR`, 2: write ports, ≥ 1.
- `ZERO_REG`, 1: when 1, register 0 reads as 0, ignores writes and is never busy.

- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hold all read outputs.
- `rd_addr`  in  NUM_RD*AW  read addresses; port i is bits [i*AW +: AW].
- `rd_data`  out  NUM_RD*WIDTH  registered read data.
- `rd_addr_out`  out  NUM_RD*AW  registered copy of `rd_addr`.
- `rd_busy`  out  NUM_RD  registered scoreboard bit for each read address.
- `we`  in  NUM_WR  write enables.
- `wa`  in  NUM_WR*AW  write addresses.
- `wd`  in  NUM_WR*WIDTH  write data.
- `claim_en`  in  1  mark `claim_addr` as having a pending write.
- `claim_addr`  in  AW  register to claim.
- `ready`  out  1  high once clearing is complete; low during CLEAR.

## Operation
- Reset is sampled at the clock edge and overrides everything else. It sets state to CLEAR, `clr_idx` to 0, all `busy` bits to 0, `rd_data`, `rd_addr_out` and `rd_busy` to 0, and `ready` to 0.
- State CLEAR:
  - Each cycle, write 0 to `mem[clr_idx]` and increment `clr_idx`.
  - When `clr_idx == DEPTH-1`, move to RUN and set `ready` to 1.
  - `we`, `claim_en` and `stall` are ignored; read outputs stay at 0.
- State RUN: remains in RUN until reset.
- Write resolution:
  - If several ports enable a write to the same address, the highest port index wins.
  - If `ZERO_REG` is set, writes to address 0 are discarded.
  - Writes commit at the edge regardless of `stall`.
- Forwarding, per read port i, when `stall` is 0:
  - `rd_data[i]` gets the winning in-flight `wd` if any port writes `rd_addr[i]` this cycle (subject to the `ZERO_REG` discard). Otherwise it gets `mem[rd_addr[i]]`.
  - `rd_addr_out[i]` gets `rd_addr[i]`.
  - `rd_busy[i]` gets `busy_next[rd_addr[i]]`.
- Stall: when `stall` is 1 in RUN, `rd_data`, `rd_addr_out` and `rd_busy` hold their values.
- Scoreboard:
  - A committed write to address a clears `busy[a]`.
  - `claim_en` sets `busy[claim_addr]`.
  - If a claim and a write hit the same address in the same cycle, the claim wins and the bit ends set.
  - If `ZERO_REG` is set, `busy[0]` is constantly 0.
  - `busy_next` is the value after that cycle's updates.
- Address width: addresses are exactly `AW` bits, so there is no out-of-range case.

## Timing
- Read latency is 1 cycle: address presented at edge N gives data valid after edge N.
- Write-to-read: a write and a read of the same address in the same cycle return the new data after the same edge, so no bubble is needed.
- `ready` rises exactly `DEPTH` edges after the last edge at which `reset` was sampled high.
- Reset asserted during CLEAR restarts the clear from index 0.
- Reset asserted during RUN discards any in-progress writes and claims.
- Claim then read: a claim at edge N is visible on `rd_busy` for a read presented at edge N (uses `busy_next`).

## Test plan
- **Reset and clear:** hold `reset` for 2 cycles, DEPTH=32 → `ready` goes high on the 32nd edge after reset is released; every register then reads 0; writes issued during CLEAR have no effect.
- **Write and forwarding:** write `wd0=0xDEADBEEF` to r5 while reading r5 in the same cycle → `rd_data[0]=0xDEADBEEF` after that edge; a read in the next cycle matches.
- **Write collision:** `we=2'b11`, both ports write r7 with `wd0=0x11` and `wd1=0x22` → a read of r7 returns 0x22, including on the forwarded path.
- **Zero register:** with ZERO_REG=1, write 0x1234 to r0 and claim r0 → r0 reads 0 and `rd_busy=0`. With ZERO_REG=0, r0 reads 0x1234.
- **Stall:** read r3=0xA, then assert `stall` for 3 cycles while changing `rd_addr` and writing r3=0xB → outputs stay at 0xA/r3 throughout; the first edge after stall is released shows the new address and data; the r3 write is retained.
- **Scoreboard:** claim r9, read r9 in the same cycle → `rd_busy=1`. Write r9 while claiming r9 → stays busy. Write r9 alone → `rd_busy=0`. Reset mid-RUN → all busy bits are 0 after clearing.
